// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and default frame parameters for the FIFO-fed UART transmitter.
package uart_pkg;
  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;
endpackage

// File: rtl/baud_tick.sv
// baud_tick: one-cycle tick every CLKS_PER_BIT cycles; clear holds the count at zero.
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  // Wrapping on tick restarts the period at zero for the next state.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear || o_tick) r_cnt <= '0;
    else r_cnt <= r_cnt + CW'(1);
  end

  assign o_tick = !i_clear && (r_cnt == LAST);
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from an upstream FIFO and sends them as 8N1-style UART frames.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_en,
  input  logic                  enable,
  output logic                  tx,
  output logic                  busy,
  output logic [15:0]           frame_count
);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  state_t                r_state;
  logic                  r_tx;
  logic                  r_read_en;
  logic                  r_busy;
  logic [15:0]           r_frame_count;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [IW-1:0]         r_idx;
  logic                  w_clear;
  logic                  w_tick;

  assign w_clear = (r_state == IDLE) || (r_state == FETCH) || (r_state == LOAD);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .i_clock(clock),
    .i_reset(reset),
    .i_clear(w_clear),
    .o_tick (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tx          <= 1'b1;
      r_read_en     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
      r_shift       <= '0;
      r_idx         <= '0;
    end else begin
      r_read_en <= 1'b0;
      case (r_state)
        IDLE: if (enable && !fifo_empty) begin
          r_state   <= FETCH;
          r_read_en <= 1'b1;
          r_busy    <= 1'b1;
        end
        FETCH: r_state <= LOAD;
        LOAD: begin
          r_shift <= data_out;
          r_idx   <= '0;
          r_tx    <= 1'b0;
          r_state <= START;
        end
        START: if (w_tick) begin
          r_tx    <= r_shift[0];
          r_shift <= r_shift >> 1;
          r_state <= DATA;
        end
        // tx already holds bit r_idx; on its final tick move to the stop bit.
        DATA: if (w_tick) begin
          if (r_idx == LAST_BIT) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 1'b1;
          end
        end
        STOP: if (w_tick) begin
          r_state       <= IDLE;
          r_busy        <= 1'b0;
          r_frame_count <= r_frame_count + 16'd1;
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx          = r_tx;
  assign read_en     = r_read_en;
  assign busy        = r_busy;
  assign frame_count = r_frame_count;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a queue-backed FIFO and compares every cycle against
// a timeline model that expands each popped byte into its expected serial waveform.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  data_out = 8'h00;
  logic        read_en;
  logic        enable = 1'b0;
  logic        tx;
  logic        busy;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .data_out   (data_out),
    .read_en    (read_en),
    .enable     (enable),
    .tx         (tx),
    .busy       (busy),
    .frame_count(frame_count)
  );

  typedef struct packed {
    logic tx;
    logic rd;
    logic last;
  } ev_t;

  typedef struct {
    logic [7:0]  b;
    logic [9:0]  line_bits;
    logic [15:0] cnt;
  } vec_t;

  ev_t         exp_q[$];
  logic [7:0]  fifo_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc_no = 0;
  logic [15:0] m_cnt = 16'h0;
  logic        m_inc = 1'b0;
  logic        m_busy = 1'b0;
  logic        pop_due = 1'b0;
  logic        s_tx, s_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc_no);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: predict, advance, drive the FIFO side, then compare at the falling edge.
  task automatic cyc();
    ev_t e;
    logic x_tx, x_rd, x_busy, bt;
    logic [7:0] b;
    if (m_inc) begin
      m_cnt = m_cnt + 16'd1;
      m_inc = 1'b0;
    end
    if (reset) begin
      exp_q.delete();
      m_cnt = 16'h0;
      x_tx = 1'b1; x_rd = 1'b0; x_busy = 1'b0;
    end else begin
      if (!m_busy && exp_q.size() == 0 && enable && !fifo_empty) begin
        b = fifo_q[0];
        e = '{tx: 1'b1, rd: 1'b1, last: 1'b0};
        exp_q.push_back(e);
        e = '{tx: 1'b1, rd: 1'b0, last: 1'b0};
        exp_q.push_back(e);
        for (int i = 0; i < 10; i++)
          for (int k = 0; k < CPB; k++) begin
            bt = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            e = '{tx: bt, rd: 1'b0, last: (i == 9 && k == CPB - 1)};
            exp_q.push_back(e);
          end
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        x_tx = e.tx; x_rd = e.rd; x_busy = 1'b1; m_inc = e.last;
      end else begin
        x_tx = 1'b1; x_rd = 1'b0; x_busy = 1'b0;
      end
    end
    m_busy = x_busy;
    @(posedge clk);
    #1;
    if (pop_due && fifo_q.size() != 0) data_out = fifo_q.pop_front();
    else data_out = 8'($urandom);
    pop_due = 1'b0;
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
    cyc_no++;
    s_tx = tx;
    s_rd = read_en;
    pop_due = read_en;
    chk("tx/read_en/busy/frame_count", {13'h0, tx, read_en, busy, frame_count},
        {13'h0, x_tx, x_rd, x_busy, m_cnt});
  endtask

  task automatic wait_rd(input string name);
    int k;
    k = 0;
    while (!s_rd && k < 200) begin
      cyc();
      k++;
    end
    if (!s_rd) chk({name, " read_en timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    vec_t vecs[6];
    logic smp[40];
    int bad, rd_seen;
    logic [15:0] base;

    vecs[0] = '{b: 8'hA5, line_bits: 10'b1101001010, cnt: 16'd1};
    vecs[1] = '{b: 8'h00, line_bits: 10'b1000000000, cnt: 16'd2};
    vecs[2] = '{b: 8'hFF, line_bits: 10'b1111111110, cnt: 16'd3};
    vecs[3] = '{b: 8'h3C, line_bits: 10'b1001111000, cnt: 16'd4};
    vecs[4] = '{b: 8'h55, line_bits: 10'b1010101010, cnt: 16'd5};
    vecs[5] = '{b: 8'h81, line_bits: 10'b1100000010, cnt: 16'd6};

    @(negedge clk);
    run_cycles(2);
    reset = 1'b0;

    // Empty FIFO with enable high: the line must stay idle.
    enable = 1'b1;
    run_cycles(100);

    // Single frames: waveform, length and running count against hand-derived constants.
    foreach (vecs[v]) begin
      push(vecs[v].b);
      wait_rd("table");
      cyc();
      for (int i = 0; i < 40; i++) begin
        cyc();
        smp[i] = s_tx;
      end
      bad = 0;
      for (int i = 0; i < 40; i++) if (smp[i] !== vecs[v].line_bits[i/CPB]) bad++;
      chk("serial waveform", bad, 0);
      cyc();
      chk("busy after frame", {31'h0, busy}, 32'd0);
      chk("frame_count table", {16'h0, frame_count}, {16'h0, vecs[v].cnt});
    end

    // Three queued bytes go out back to back.
    base = m_cnt;
    push(8'h00); push(8'hFF); push(8'h3C);
    run_cycles(3 * 43 + 5);
    chk("fifo_empty after burst", {31'h0, fifo_empty}, 32'd1);
    chk("frame_count burst", {16'h0, frame_count}, {16'h0, base + 16'd3});

    // Drop enable during data bit 3: frame completes, the queued byte waits.
    push(8'h55); push(8'h99);
    wait_rd("enable drop");
    run_cycles(1 + CPB + 3 * CPB + 2);
    enable = 1'b0;
    rd_seen = 0;
    for (int i = 0; i < 80; i++) begin
      cyc();
      if (s_rd) rd_seen++;
    end
    chk("read_en while disabled", rd_seen, 0);
    chk("queued byte kept", fifo_q.size(), 1);
    enable = 1'b1;
    run_cycles(50);
    chk("queued byte sent", fifo_q.size(), 0);

    // Reset during data bit 5 aborts the frame; the next byte is clean.
    push(8'h5A);
    wait_rd("reset abort");
    run_cycles(1 + CPB + 5 * CPB + 2);
    reset = 1'b1;
    cyc();
    chk("tx after reset", {31'h0, tx}, 32'd1);
    chk("busy after reset", {31'h0, busy}, 32'd0);
    chk("frame_count after reset", {16'h0, frame_count}, 32'd0);
    reset = 1'b0;
    push(8'hC3);
    run_cycles(50);
    chk("frame_count after clean frame", {16'h0, frame_count}, 32'd1);

    // Preload the counter at its top value and check the wrap.
    force dut.r_frame_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    cyc();
    release dut.r_frame_count;
    push(8'h42);
    run_cycles(50);
    chk("frame_count wrap", {16'h0, frame_count}, 32'd0);

    // Random traffic with enable toggling, then drain.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(11) == 0 && fifo_q.size() < 4) push(8'($urandom));
      enable = ($urandom_range(7) != 0);
      cyc();
    end
    enable = 1'b1;
    for (int i = 0; i < 1500 && (fifo_q.size() != 0 || busy); i++) cyc();
    chk("random drain", {30'h0, fifo_empty, busy}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
